// File: rtl/pwm_timer_ctrl.sv
// PWM timebase: prescaler, period counter and shadow-buffered config.
// Config changes land only at a period wrap (or at once while idle).
module pwm_timer_ctrl #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic               oneshot,
  input  logic [PRESC_W-1:0] presc,
  input  logic               cnt_clr,
  input  logic               upd_req,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [7:0]         functions_in,
  input  logic [CNT_W-1:0]   compare1_in,
  input  logic [CNT_W-1:0]   compare2_in,
  output logic               pwm_en,
  output logic [CNT_W-1:0]   period,
  output logic [7:0]         functions,
  output logic [CNT_W-1:0]   compare1,
  output logic [CNT_W-1:0]   compare2,
  output logic [CNT_W-1:0]   count_val,
  output logic               ovf,
  output logic               upd_pending,
  output logic               upd_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   cmp1_q, cmp1_d;
  logic [CNT_W-1:0]   cmp2_q, cmp2_d;
  logic [7:0]         fn_q, fn_d;
  logic [CNT_W-1:0]   pper_q, pper_d;
  logic [CNT_W-1:0]   pcmp1_q, pcmp1_d;
  logic [CNT_W-1:0]   pcmp2_q, pcmp2_d;
  logic [7:0]         pfn_q, pfn_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               ack_q, ack_d;
  logic               en_q, en_d;
  logic               running, tick, wrap, apply;

  always_comb begin
    running = (state_q != IDLE);
    tick    = running && (pcnt_q == presc);
    // cnt_clr swallows a coincident wrap entirely
    wrap    = tick && (cnt_q == per_q) && !cnt_clr;
    apply   = pend_q && ((state_q == IDLE) || wrap);

    state_d = state_q;
    case (state_q)
      IDLE:    if (en_req) state_d = RUN;
      RUN: begin
        if (wrap && oneshot) state_d = IDLE;
        else if (!en_req)    state_d = DRAIN;
      end
      DRAIN: begin
        if (wrap)        state_d = IDLE;
        else if (en_req) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!running || cnt_clr) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    per_d  = apply ? pper_q  : per_q;
    cmp1_d = apply ? pcmp1_q : cmp1_q;
    cmp2_d = apply ? pcmp2_q : cmp2_q;
    fn_d   = apply ? pfn_q   : fn_q;

    pper_d  = upd_req ? period_in    : pper_q;
    pcmp1_d = upd_req ? compare1_in  : pcmp1_q;
    pcmp2_d = upd_req ? compare2_in  : pcmp2_q;
    pfn_d   = upd_req ? functions_in : pfn_q;
    pend_d  = upd_req | (pend_q & ~apply);

    ovf_d = wrap;
    ack_d = apply;
    en_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      cmp1_q  <= '0;
      cmp2_q  <= '0;
      fn_q    <= '0;
      pper_q  <= '0;
      pcmp1_q <= '0;
      pcmp2_q <= '0;
      pfn_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      cmp1_q  <= cmp1_d;
      cmp2_q  <= cmp2_d;
      fn_q    <= fn_d;
      pper_q  <= pper_d;
      pcmp1_q <= pcmp1_d;
      pcmp2_q <= pcmp2_d;
      pfn_q   <= pfn_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
    end
  end

  assign pwm_en      = en_q;
  assign period      = per_q;
  assign functions   = fn_q;
  assign compare1    = cmp1_q;
  assign compare2    = cmp2_q;
  assign count_val   = cnt_q;
  assign ovf         = ovf_q;
  assign upd_pending = pend_q;
  assign upd_ack     = ack_q;

endmodule
